cc_gate_xor_acc: RTL and testbench

Parametrised, registered successor to the single-bit XOR gate.
- Computes the WIDTH-bit bitwise XOR of two operand words.
- Operates in one of two modes:
  - pair mode: one result per accepted beat.
  - frame mode: XOR-folds up to FRAME_LEN beats into a single result word.
- Sits between a producer and a consumer, with a valid/ready handshake on both sides.
- Used for checksum folding and data scrambling in the datapath examples.

---
 rtl/cc_gate_xor_pkg.sv | 12 +
 rtl/cc_gate_xor_vec.sv | 13 +
 rtl/cc_gate_xor_acc.sv | 125 ++++++++++++
 tb/tb_cc_gate_xor_acc.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/cc_gate_xor_pkg.sv
// Shared state encoding and mode constants for the XOR gate/accumulator slice.
package cc_gate_xor_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ACC  = 1'b1
    } state_t;

    localparam logic MODE_PAIR  = 1'b0;
    localparam logic MODE_FRAME = 1'b1;

endpackage

// File: rtl/cc_gate_xor_vec.sv
// Bitwise XOR of two operand words.
// Latency: combinational. Backpressure: none, pure datapath.
module cc_gate_xor_vec #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] opA,
    input  logic [WIDTH-1:0] opB,
    output logic [WIDTH-1:0] x
);

    assign x = opA ^ opB;

endmodule

// File: rtl/cc_gate_xor_acc.sv
// Registered XOR gate: pair mode emits a ^ b per beat, frame mode folds up to FRAME_LEN beats.
// Latency: result one clock after the accepting edge of the final beat; 1 beat/cycle sustained.
// Backpressure: ready_Out = !valid_Out | ready_In; result held stable while stalled. Option: CC_GATE_XOR_ACC_PARITY_EN.
module cc_gate_xor_acc
    import cc_gate_xor_pkg::*;
#(
    parameter  int WIDTH     = 8,
    parameter  int FRAME_LEN = 4,
    localparam int CNT_W     = $clog2(FRAME_LEN + 1)
) (
    input  logic             cc_gate_xor_acc_CLOCK_50,
    input  logic             cc_gate_xor_acc_RESET_InLow,
    input  logic             cc_gate_xor_acc_mode_In,
    input  logic [WIDTH-1:0] cc_gate_xor_acc_a_In,
    input  logic [WIDTH-1:0] cc_gate_xor_acc_b_In,
    input  logic             cc_gate_xor_acc_last_In,
    input  logic             cc_gate_xor_acc_valid_In,
    output logic             cc_gate_xor_acc_ready_Out,
    output logic [WIDTH-1:0] cc_gate_xor_acc_z_Out,
    output logic [CNT_W-1:0] cc_gate_xor_acc_count_Out,
`ifdef CC_GATE_XOR_ACC_PARITY_EN
    output logic             cc_gate_xor_acc_parity_Out,
`endif
    output logic             cc_gate_xor_acc_valid_Out,
    input  logic             cc_gate_xor_acc_ready_In
);

    localparam bit SINGLE_BEAT = (FRAME_LEN == 1);

    state_t           state;
    logic [WIDTH-1:0] acc;
    logic [CNT_W-1:0] cnt;
    logic             modeLat;

    logic [WIDTH-1:0] x;
    logic             accept;
    logic [CNT_W-1:0] cntNext;
    logic             closeFrame;
    logic             loadRes;
    logic [WIDTH-1:0] resNext;
    logic [CNT_W-1:0] resCnt;

    cc_gate_xor_vec #(.WIDTH(WIDTH)) uVec (
        .opA (cc_gate_xor_acc_a_In),
        .opB (cc_gate_xor_acc_b_In),
        .x   (x)
    );

    // Held low during reset so the producer never sees a phantom accept.
    assign cc_gate_xor_acc_ready_Out = cc_gate_xor_acc_RESET_InLow &
                                       (!cc_gate_xor_acc_valid_Out | cc_gate_xor_acc_ready_In);
    assign accept  = cc_gate_xor_acc_valid_In & cc_gate_xor_acc_ready_Out;
    assign cntNext = cnt + CNT_W'(1);

    // A frame can only be opened in frame mode; a pair latch closes immediately as a safety net.
    assign closeFrame = cc_gate_xor_acc_last_In | (cntNext == CNT_W'(FRAME_LEN)) |
                        (modeLat == MODE_PAIR);

    always_comb begin
        loadRes = 1'b0;
        resNext = x;
        resCnt  = CNT_W'(1);
        if (accept) begin
            if (state == ST_IDLE) begin
                loadRes = (cc_gate_xor_acc_mode_In == MODE_PAIR) | cc_gate_xor_acc_last_In |
                          SINGLE_BEAT;
            end else if (closeFrame) begin
                loadRes = 1'b1;
                resNext = acc ^ x;
                resCnt  = cntNext;
            end
        end
    end

    always_ff @(posedge cc_gate_xor_acc_CLOCK_50 or negedge cc_gate_xor_acc_RESET_InLow) begin
        if (!cc_gate_xor_acc_RESET_InLow) begin
            state                     <= ST_IDLE;
            acc                       <= '0;
            cnt                       <= '0;
            modeLat                   <= MODE_PAIR;
            cc_gate_xor_acc_z_Out     <= '0;
            cc_gate_xor_acc_count_Out <= '0;
            cc_gate_xor_acc_valid_Out <= 1'b0;
`ifdef CC_GATE_XOR_ACC_PARITY_EN
            cc_gate_xor_acc_parity_Out <= 1'b0;
`endif
        end else begin
            if (loadRes) begin
                cc_gate_xor_acc_z_Out     <= resNext;
                cc_gate_xor_acc_count_Out <= resCnt;
                cc_gate_xor_acc_valid_Out <= 1'b1;
`ifdef CC_GATE_XOR_ACC_PARITY_EN
                cc_gate_xor_acc_parity_Out <= ^resNext;
`endif
            end else if (cc_gate_xor_acc_valid_Out & cc_gate_xor_acc_ready_In) begin
                cc_gate_xor_acc_valid_Out <= 1'b0;
            end

            if (accept) begin
                case (state)
                    ST_IDLE: begin
                        if (!loadRes) begin
                            acc     <= x;
                            cnt     <= CNT_W'(1);
                            modeLat <= cc_gate_xor_acc_mode_In;
                            state   <= ST_ACC;
                        end
                    end
                    ST_ACC: begin
                        if (closeFrame) begin
                            acc   <= '0;
                            cnt   <= '0;
                            state <= ST_IDLE;
                        end else begin
                            acc <= acc ^ x;
                            cnt <= cntNext;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_cc_gate_xor_acc.sv
// Directed bench for cc_gate_xor_acc (WIDTH=8, FRAME_LEN=4) with an expected-result queue.
module tb_cc_gate_xor_acc;

    localparam int WIDTH     = 8;
    localparam int FRAME_LEN = 4;
    localparam int CNT_W     = $clog2(FRAME_LEN + 1);

    typedef struct packed {
        logic [WIDTH-1:0] z;
        logic [CNT_W-1:0] cnt;
        logic             par;
    } exp_t;

    logic             clk = 1'b0;
    logic             rstN;
    logic             modeIn;
    logic [WIDTH-1:0] aIn;
    logic [WIDTH-1:0] bIn;
    logic             lastIn;
    logic             validIn;
    logic             readyOut;
    logic [WIDTH-1:0] zOut;
    logic [CNT_W-1:0] countOut;
    logic             validOut;
    logic             readyIn;
`ifdef CC_GATE_XOR_ACC_PARITY_EN
    logic             parityOut;
`endif

    exp_t expQ[$];
    int   checkCnt = 0;
    int   passCnt  = 0;

    always #5 clk = ~clk;

    cc_gate_xor_acc #(.WIDTH(WIDTH), .FRAME_LEN(FRAME_LEN)) dut (
        .cc_gate_xor_acc_CLOCK_50    (clk),
        .cc_gate_xor_acc_RESET_InLow (rstN),
        .cc_gate_xor_acc_mode_In     (modeIn),
        .cc_gate_xor_acc_a_In        (aIn),
        .cc_gate_xor_acc_b_In        (bIn),
        .cc_gate_xor_acc_last_In     (lastIn),
        .cc_gate_xor_acc_valid_In    (validIn),
        .cc_gate_xor_acc_ready_Out   (readyOut),
        .cc_gate_xor_acc_z_Out       (zOut),
        .cc_gate_xor_acc_count_Out   (countOut),
`ifdef CC_GATE_XOR_ACC_PARITY_EN
        .cc_gate_xor_acc_parity_Out  (parityOut),
`endif
        .cc_gate_xor_acc_valid_Out   (validOut),
        .cc_gate_xor_acc_ready_In    (readyIn)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCnt++;
        assert (obs === exp) passCnt++;
        else $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic pushExp(input logic [WIDTH-1:0] z, input int n);
        exp_t e;
        e.z   = z;
        e.cnt = CNT_W'(n);
        e.par = ^z;
        expQ.push_back(e);
    endtask

    // Drive one beat; it is sampled at the next rising edge, inputs change 1ns after it.
    task automatic beat(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic mode, input logic last);
        aIn = a; bIn = b; modeIn = mode; lastIn = last; validIn = 1'b1;
        @(posedge clk); #1;
        validIn = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    // Scoreboard: an output is consumed at the rising edge following a negedge with valid & ready.
    always @(negedge clk) begin
        if (rstN && validOut && readyIn) begin
            if (expQ.size() == 0) begin
                chk("unexpected_output", {24'd0, zOut}, 32'hDEAD);
            end else begin
                exp_t e;
                e = expQ.pop_front();
                chk("sb_z", 32'(zOut), 32'(e.z));
                chk("sb_count", 32'(countOut), 32'(e.cnt));
`ifdef CC_GATE_XOR_ACC_PARITY_EN
                chk("sb_parity", 32'(parityOut), 32'(e.par));
`endif
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rstN = 1'b0; modeIn = 1'b0; aIn = '0; bIn = '0; lastIn = 1'b0;
        validIn = 1'b0; readyIn = 1'b1;
        #12;
        chk("rst_ready", 32'(readyOut), 32'd0);
        chk("rst_valid", 32'(validOut), 32'd0);
        chk("rst_z", 32'(zOut), 32'd0);
        chk("rst_count", 32'(countOut), 32'd0);
        @(posedge clk); #1;
        rstN = 1'b1;
        #1;
        chk("post_rst_ready", 32'(readyOut), 32'd1);

        // Pair mode, then two back-to-back pair beats
        pushExp(8'hAA, 1);
        beat(8'hA5, 8'h0F, 1'b0, 1'b0);
        chk("pair_valid", 32'(validOut), 32'd1);
        chk("pair_z", 32'(zOut), 32'hAA);
        idle(1);
        chk("pair_one_cycle", 32'(validOut), 32'd0);
        pushExp(8'h07, 1);
        pushExp(8'h3C, 1);
        beat(8'h07, 8'h00, 1'b0, 1'b1);
        beat(8'h3F, 8'h03, 1'b0, 1'b0);
        chk("pair_b2b_z", 32'(zOut), 32'h3C);
        idle(1);

        // Full frame
        pushExp(8'h0F, 4);
        beat(8'h01, 8'h00, 1'b1, 1'b0);
        chk("frame_b1_novalid", 32'(validOut), 32'd0);
        beat(8'h02, 8'h00, 1'b1, 1'b0);
        chk("frame_b2_novalid", 32'(validOut), 32'd0);
        beat(8'h04, 8'h00, 1'b1, 1'b0);
        chk("frame_b3_novalid", 32'(validOut), 32'd0);
        beat(8'h08, 8'h00, 1'b1, 1'b0);
        chk("frame_valid", 32'(validOut), 32'd1);
        chk("frame_count", 32'(countOut), 32'd4);
        idle(1);

        // Early last, then a fresh frame
        pushExp(8'hF3, 2);
        beat(8'hFF, 8'h0F, 1'b1, 1'b0);
        beat(8'h00, 8'h03, 1'b1, 1'b1);
        chk("early_z", 32'(zOut), 32'hF3);
        pushExp(8'h33, 2);
        beat(8'h11, 8'h00, 1'b1, 1'b0);
        chk("fresh_b1_novalid", 32'(validOut), 32'd0);
        beat(8'h22, 8'h00, 1'b1, 1'b1);
        chk("fresh_z", 32'(zOut), 32'h33);
        idle(1);

        // Backpressure
        readyIn = 1'b0;
        pushExp(8'h3C, 1);
        beat(8'h3C, 8'h00, 1'b0, 1'b0);
        pushExp(8'h5A, 1);
        aIn = 8'h55; bIn = 8'h0F; modeIn = 1'b0; lastIn = 1'b0; validIn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("bp_z", 32'(zOut), 32'h3C);
            chk("bp_count", 32'(countOut), 32'd1);
            chk("bp_valid", 32'(validOut), 32'd1);
            chk("bp_ready", 32'(readyOut), 32'd0);
        end
        readyIn = 1'b1;
        #1;
        chk("bp_release_ready", 32'(readyOut), 32'd1);
        @(posedge clk); #1;
        validIn = 1'b0;
        chk("bp_new_z", 32'(zOut), 32'h5A);
        chk("bp_new_valid", 32'(validOut), 32'd1);
        idle(1);

        // Reset mid-frame
        beat(8'h01, 8'h00, 1'b1, 1'b0);
        beat(8'h02, 8'h00, 1'b1, 1'b0);
        #2 rstN = 1'b0;
        #1;
        chk("mid_rst_z", 32'(zOut), 32'd0);
        chk("mid_rst_count", 32'(countOut), 32'd0);
        chk("mid_rst_valid", 32'(validOut), 32'd0);
        chk("mid_rst_ready", 32'(readyOut), 32'd0);
        #2 rstN = 1'b1;
        @(posedge clk); #1;
        pushExp(8'hF0, 4);
        beat(8'h10, 8'h00, 1'b1, 1'b0);
        beat(8'h20, 8'h00, 1'b1, 1'b0);
        beat(8'h40, 8'h00, 1'b1, 1'b0);
        chk("post_rst_b3_novalid", 32'(validOut), 32'd0);
        beat(8'h80, 8'h00, 1'b1, 1'b0);
        chk("post_rst_z", 32'(zOut), 32'hF0);
        chk("post_rst_count", 32'(countOut), 32'd4);
        idle(1);

        // Mode toggled mid-frame is ignored
        pushExp(8'h0F, 4);
        beat(8'h01, 8'h00, 1'b1, 1'b0);
        beat(8'h02, 8'h00, 1'b0, 1'b0);
        chk("mode_b2_novalid", 32'(validOut), 32'd0);
        beat(8'h04, 8'h00, 1'b0, 1'b0);
        chk("mode_b3_novalid", 32'(validOut), 32'd0);
        beat(8'h08, 8'h00, 1'b0, 1'b0);
        chk("mode_valid", 32'(validOut), 32'd1);
        chk("mode_count", 32'(countOut), 32'd4);
        idle(3);

        chk("sb_drained", 32'(expQ.size()), 32'd0);
        $display("%0d/%0d checks passed", passCnt, checkCnt);
        $finish;
    end

endmodule
